// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared constants for the I2C register sequencer: core register map,
// control/status bit values, response codes and sequencer state encodings.
package i2c_reg_sequencer_pkg;

  // Core register addresses (TXR/RXR and CR/SR share an address by direction)
  localparam logic [2:0] REG_PRER_LO = 3'd0;
  localparam logic [2:0] REG_PRER_HI = 3'd1;
  localparam logic [2:0] REG_CTR     = 3'd2;
  localparam logic [2:0] REG_TXR     = 3'd3;
  localparam logic [2:0] REG_RXR     = 3'd3;
  localparam logic [2:0] REG_CR      = 3'd4;
  localparam logic [2:0] REG_SR      = 3'd4;

  // CTR and CR command bytes
  localparam logic [7:0] CTR_EN         = 8'h80;
  localparam logic [7:0] CR_STA_WR      = 8'h90;
  localparam logic [7:0] CR_WR          = 8'h10;
  localparam logic [7:0] CR_WR_STO      = 8'h50;
  localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CR_STO         = 8'h40;

  // SR bit positions
  localparam int SR_TIP   = 1;
  localparam int SR_AL    = 5;
  localparam int SR_BUSY  = 6;
  localparam int SR_RXACK = 7;

  // Response codes
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_AL      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Sequencer states
  localparam logic [3:0] ST_INIT0     = 4'd0;
  localparam logic [3:0] ST_INIT1     = 4'd1;
  localparam logic [3:0] ST_INIT2     = 4'd2;
  localparam logic [3:0] ST_IDLE      = 4'd3;
  localparam logic [3:0] ST_TXR       = 4'd4;
  localparam logic [3:0] ST_CR        = 4'd5;
  localparam logic [3:0] ST_POLL      = 4'd6;
  localparam logic [3:0] ST_STOP_CR   = 4'd7;
  localparam logic [3:0] ST_STOP_POLL = 4'd8;
  localparam logic [3:0] ST_TO_CR     = 4'd9;
  localparam logic [3:0] ST_RXR       = 4'd10;
  localparam logic [3:0] ST_DONE      = 4'd11;

  // Latched command
  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rgn;
    logic [7:0] wdata;
  } cmd_t;

  // Address byte sent on the bus: 7-bit device address plus R/W bit
  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

endpackage

// File: rtl/i2c_seq_bus_port.sv
// Single register access engine for the I2C core register port.
// Owns the stb/ack handshake: address, data and we are held from the
// accepting edge until ack, and stb always drops for at least one cycle
// between accesses because a new request is only taken once done has cleared.
module i2c_seq_bus_port
  import i2c_reg_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i
);

  logic       stb_r;
  logic [2:0] adr_r;
  logic [7:0] dat_r;
  logic       we_r;
  logic       done_r;
  logic [7:0] rdata_r;

  assign ready   = !stb_r && !done_r;
  assign done    = done_r;
  assign rdata   = rdata_r;
  assign m_adr_o = adr_r;
  assign m_dat_o = dat_r;
  assign m_we_o  = we_r;
  assign m_stb_o = stb_r;

  // Launch an access on request, hold it until ack, then pulse done with read data
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_r   <= 1'b0;
      adr_r   <= 3'd0;
      dat_r   <= 8'h00;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      done_r <= 1'b0;
      if (stb_r) begin
        if (m_ack_i) begin
          stb_r   <= 1'b0;
          done_r  <= 1'b1;
          rdata_r <= m_dat_i;
        end
      end else if (req && !done_r) begin
        stb_r <= 1'b1;
        adr_r <= addr;
        we_r  <= we;
        dat_r <= we ? wdata : 8'h00;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Command-level sequencer for the i2c_master_top core: initialises the
// prescaler and enable, then turns single-byte register read/write commands
// into TXR/CR writes and SR polling, reporting NACK, arbitration loss and
// poll timeout on a one-cycle response port.
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter logic [15:0] PRESCALE     = 16'd99,
  parameter logic [19:0] POLL_TIMEOUT = 20'hFFFFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic       m_ack_i
);

  logic [3:0]  state_r;
  logic [1:0]  phase_r;
  cmd_t        cmd_r;
  logic [1:0]  err_r;
  logic [7:0]  rd_data_r;
  logic [19:0] poll_cnt_r;
  logic        acc_pend_r;
  logic        cmd_ready_r;
  logic        rsp_valid_r;
  logic [7:0]  rsp_rdata_r;
  logic [1:0]  rsp_err_r;

  logic        acc_en_s;
  logic [2:0]  acc_addr_s;
  logic        acc_we_s;
  logic [7:0]  acc_wdata_s;
  logic        acc_req_s;
  logic [7:0]  txr_byte_s;
  logic [7:0]  cr_byte_s;
  logic        last_phase_s;
  logic        ack_checked_s;
  logic        poll_expired_s;
  logic        bus_ready_s;
  logic        bus_done_s;
  logic [7:0]  bus_rdata_s;

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  assign acc_req_s      = acc_en_s && !acc_pend_r;
  assign last_phase_s   = cmd_r.rw ? (phase_r == 2'd3) : (phase_r == 2'd2);
  assign ack_checked_s  = !(cmd_r.rw && (phase_r == 2'd3));
  assign poll_expired_s = (poll_cnt_r >= POLL_TIMEOUT);

  // TXR and CR bytes for the current phase of the command
  always_comb begin
    txr_byte_s = 8'h00;
    cr_byte_s  = CR_RD_NACK_STO;
    case (phase_r)
      2'd0: begin
        txr_byte_s = addr_byte(cmd_r.dev, 1'b0);
        cr_byte_s  = CR_STA_WR;
      end
      2'd1: begin
        txr_byte_s = cmd_r.rgn;
        cr_byte_s  = CR_WR;
      end
      2'd2: begin
        if (cmd_r.rw) begin
          txr_byte_s = addr_byte(cmd_r.dev, 1'b1);
          cr_byte_s  = CR_STA_WR;
        end else begin
          txr_byte_s = cmd_r.wdata;
          cr_byte_s  = CR_WR_STO;
        end
      end
      default: begin
        txr_byte_s = 8'h00;
        cr_byte_s  = CR_RD_NACK_STO;
      end
    endcase
  end

  // Register access requested by each state
  always_comb begin
    acc_en_s    = 1'b0;
    acc_addr_s  = 3'd0;
    acc_we_s    = 1'b0;
    acc_wdata_s = 8'h00;
    case (state_r)
      ST_INIT0: begin
        acc_en_s = 1'b1; acc_addr_s = REG_PRER_LO; acc_we_s = 1'b1; acc_wdata_s = PRESCALE[7:0];
      end
      ST_INIT1: begin
        acc_en_s = 1'b1; acc_addr_s = REG_PRER_HI; acc_we_s = 1'b1; acc_wdata_s = PRESCALE[15:8];
      end
      ST_INIT2: begin
        acc_en_s = 1'b1; acc_addr_s = REG_CTR; acc_we_s = 1'b1; acc_wdata_s = CTR_EN;
      end
      ST_TXR: begin
        acc_en_s = 1'b1; acc_addr_s = REG_TXR; acc_we_s = 1'b1; acc_wdata_s = txr_byte_s;
      end
      ST_CR: begin
        acc_en_s = 1'b1; acc_addr_s = REG_CR; acc_we_s = 1'b1; acc_wdata_s = cr_byte_s;
      end
      ST_POLL, ST_STOP_POLL: begin
        acc_en_s = 1'b1; acc_addr_s = REG_SR; acc_we_s = 1'b0;
      end
      ST_STOP_CR, ST_TO_CR: begin
        acc_en_s = 1'b1; acc_addr_s = REG_CR; acc_we_s = 1'b1; acc_wdata_s = CR_STO;
      end
      ST_RXR: begin
        acc_en_s = 1'b1; acc_addr_s = REG_RXR; acc_we_s = 1'b0;
      end
      default: begin
        acc_en_s = 1'b0;
      end
    endcase
  end

  i2c_seq_bus_port u_bus_port (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (acc_req_s),
    .addr    (acc_addr_s),
    .we      (acc_we_s),
    .wdata   (acc_wdata_s),
    .ready   (bus_ready_s),
    .done    (bus_done_s),
    .rdata   (bus_rdata_s),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_we_o  (m_we_o),
    .m_stb_o (m_stb_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i)
  );

  // Phase FSM, poll/timeout counter and response registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_INIT0;
      phase_r     <= 2'd0;
      cmd_r       <= '{rw: 1'b0, dev: 7'h00, rgn: 8'h00, wdata: 8'h00};
      err_r       <= ERR_OK;
      rd_data_r   <= 8'h00;
      poll_cnt_r  <= 20'd0;
      acc_pend_r  <= 1'b0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= ERR_OK;
    end else begin
      rsp_valid_r <= 1'b0;
      if (acc_req_s && bus_ready_s) begin
        acc_pend_r <= 1'b1;
      end else if (bus_done_s) begin
        acc_pend_r <= 1'b0;
      end
      case (state_r)
        ST_INIT0: if (bus_done_s) state_r <= ST_INIT1;
        ST_INIT1: if (bus_done_s) state_r <= ST_INIT2;
        ST_INIT2: begin
          if (bus_done_s) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_r       <= '{rw: cmd_rw, dev: cmd_dev, rgn: cmd_reg, wdata: cmd_wdata};
            cmd_ready_r <= 1'b0;
            phase_r     <= 2'd0;
            err_r       <= ERR_OK;
            rd_data_r   <= 8'h00;
            state_r     <= ST_TXR;
          end
        end
        ST_TXR: if (bus_done_s) state_r <= ST_CR;
        ST_CR: begin
          if (bus_done_s) begin
            poll_cnt_r <= 20'd0;
            state_r    <= ST_POLL;
          end
        end
        ST_POLL: begin
          if (poll_cnt_r != 20'hFFFFF) poll_cnt_r <= poll_cnt_r + 20'd1;
          if (bus_done_s) begin
            if (bus_rdata_s[SR_TIP]) begin
              if (poll_expired_s) state_r <= ST_TO_CR;
            end else if (bus_rdata_s[SR_AL]) begin
              // Arbitration lost: another master owns the bus, so no STOP
              err_r   <= ERR_AL;
              state_r <= ST_DONE;
            end else if (ack_checked_s && bus_rdata_s[SR_RXACK]) begin
              err_r   <= ERR_NACK;
              state_r <= ST_STOP_CR;
            end else if (last_phase_s) begin
              state_r <= cmd_r.rw ? ST_RXR : ST_DONE;
            end else begin
              phase_r <= phase_r + 2'd1;
              // The read-data phase has no TXR byte
              state_r <= (cmd_r.rw && (phase_r == 2'd2)) ? ST_CR : ST_TXR;
            end
          end
        end
        ST_STOP_CR: begin
          if (bus_done_s) begin
            poll_cnt_r <= 20'd0;
            state_r    <= ST_STOP_POLL;
          end
        end
        ST_STOP_POLL: begin
          if (poll_cnt_r != 20'hFFFFF) poll_cnt_r <= poll_cnt_r + 20'd1;
          if (bus_done_s) begin
            if (!bus_rdata_s[SR_BUSY]) begin
              state_r <= ST_DONE;
            end else if (poll_expired_s) begin
              // STOP already issued; give up waiting for the bus to free
              err_r   <= ERR_TIMEOUT;
              state_r <= ST_DONE;
            end
          end
        end
        ST_TO_CR: begin
          if (bus_done_s) begin
            err_r   <= ERR_TIMEOUT;
            state_r <= ST_DONE;
          end
        end
        ST_RXR: begin
          if (bus_done_s) begin
            rd_data_r <= bus_rdata_s;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= err_r;
          rsp_rdata_r <= rd_data_r;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_INIT0;
          cmd_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
